// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES MixColumns engine: FSM encoding,
// field polynomial and a column-select helper for the 128-bit work register.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mc_state_t;

    // Low byte of the AES field polynomial x^8 + x^4 + x^3 + x + 1 (0x11B).
    localparam logic [7:0] AES_POLY = 8'h1B;

    // Column 0 is the most significant word (FIPS-197 column-major order).
    function automatic logic [31:0] get_column(input logic [127:0] state, input logic [1:0] col);
        logic [31:0] word;
        case (col)
            2'd0:    word = state[127:96];
            2'd1:    word = state[95:64];
            2'd2:    word = state[63:32];
            default: word = state[31:0];
        endcase
        return word;
    endfunction

endpackage

// File: rtl/aes_mix_single_column.sv
// Combinational MixColumns / InvMixColumns of one 32-bit column; inv selects
// the inverse matrix. Byte 0 is the most significant byte of the column.
module aes_mix_single_column (
    input  logic [31:0] col_in,
    input  logic        inv,
    output logic [31:0] col_out
);

    logic [0:3][7:0] b;
    logic [0:3][7:0] x2;
    logic [0:3][7:0] x4;
    logic [0:3][7:0] x8;
    logic [0:3][7:0] r;

    assign b       = col_in;
    assign col_out = r;

    for (genvar g = 0; g < 4; g++) begin : g_byte
        localparam int I1 = (g + 1) % 4;
        localparam int I2 = (g + 2) % 4;
        localparam int I3 = (g + 3) % 4;

        aes_xtime u_x2 (.x(b[g]),  .y(x2[g]));
        aes_xtime u_x4 (.x(x2[g]), .y(x4[g]));
        aes_xtime u_x8 (.x(x4[g]), .y(x8[g]));

        // Inverse terms: 14*b_i ^ 11*b_{i+1} ^ 13*b_{i+2} ^ 9*b_{i+3}
        logic [7:0] inv_byte;
        logic [7:0] fwd_byte;
        assign inv_byte = (x8[g]  ^ x4[g]  ^ x2[g])
                        ^ (x8[I1] ^ x2[I1] ^ b[I1])
                        ^ (x8[I2] ^ x4[I2] ^ b[I2])
                        ^ (x8[I3] ^ b[I3]);
        assign fwd_byte = x2[g] ^ (x2[I1] ^ b[I1]) ^ b[I2] ^ b[I3];

        assign r[g] = inv ? inv_byte : fwd_byte;
    end

endmodule

// File: rtl/aes_xtime.sv
// GF(2^8) doubling: multiply a byte by x modulo the AES polynomial.
module aes_xtime
    import aes_pkg::*;
(
    input  logic [7:0] x,
    output logic [7:0] y
);

    assign y = {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);

endmodule

// File: rtl/aes_mixcolumns_iter.sv
// Iterative MixColumns / InvMixColumns over a full AES state, one column per
// clock, with valid/ready handshakes on input and output.
module aes_mixcolumns_iter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic         inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out
);

    mc_state_t    state;
    mc_state_t    state_next;
    logic [127:0] work;
    logic [1:0]   col;
    logic         inv_q;
    logic [31:0]  col_cur;
    logic [31:0]  col_mixed;

    assign col_cur = get_column(work, col);

    aes_mix_single_column u_mix (
        .col_in (col_cur),
        .inv    (inv_q),
        .col_out(col_mixed)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: defaulting state_next first keeps this block free of latches.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)   state_next = BUSY;
            BUSY:    if (col == 2'd3) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // NOTE: the work register is reset because state_out must read zero after
    // reset and an aborted block must leave no residue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work  <= '0;
            col   <= 2'd0;
            inv_q <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            work  <= state_in;
            inv_q <= inv;
            col   <= 2'd0;
        end else if (state == BUSY) begin
            for (int i = 0; i < 4; i++) begin
                if (col == 2'(i)) work[127 - 32*i -: 32] <= col_mixed;
            end
            col <= col + 2'd1;
        end
    end

    assign state_out = work;

endmodule

// File: tb/tb_aes_mixcolumns_iter.sv
// Self-checking bench for aes_mixcolumns_iter against a generic GF(2^8)
// matrix-multiply reference model.
module tb_aes_mixcolumns_iter;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         inv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;

    int checks = 0;
    int errors = 0;

    aes_mixcolumns_iter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .state_in (state_in),
        .inv      (inv),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .state_out(state_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Shift-and-add multiply in GF(2^8) modulo 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Circulant matrix product per column: r_i = sum_j coef[(j-i) mod 4] * b_j.
    function automatic logic [127:0] mix_model(input logic [127:0] s, input logic iv);
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        logic [127:0] r;
        if (iv) coef = '{8'd14, 8'd11, 8'd13, 8'd9};
        else    coef = '{8'd2,  8'd3,  8'd1,  8'd1};
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(coef[(j - i + 4) % 4], s[127 - 32*c - 8*j -: 8]);
                r[127 - 32*c - 8*i -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a state until accepted; returns at 1ns after the accepting edge.
    task automatic send(input logic [127:0] s, input logic iv, output bit ok);
        state_in = s;
        inv      = iv;
        in_valid = 1'b1;
        ok       = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Wait for out_valid; cycles = -1 on timeout.
    task automatic wait_out(output logic [127:0] data, output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            tick();
            cycles++;
        end
        if (!out_valid) cycles = -1;
        data = state_out;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        state_in  = '0;
        inv       = 1'b0;
        #3;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        checks++;
        if (state_out !== 128'h0) begin
            errors++;
            $display("FAIL reset_state_out got %h want 0", state_out);
        end
        #19;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fips_forward();
        logic [127:0] got;
        int           cyc;
        bit           ok;
        send(128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL fwd_accept got timeout want accept");
        end
        wait_out(got, cyc);
        checks++;
        if (cyc != 4) begin
            errors++;
            $display("FAIL fwd_latency got %0d want 4", cyc);
        end
        checks++;
        if (got !== 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6) begin
            errors++;
            $display("FAIL fwd_fips got %h want 8e4da1bc9fdc589d01010101c6c6c6c6", got);
        end
        pop();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL fwd_release got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_inverse();
        logic [127:0] vin  [2];
        logic [127:0] vexp [2];
        logic [127:0] got;
        int           cyc;
        bit           ok;
        vin[0]  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
        vexp[0] = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
        vin[1]  = 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6;
        vexp[1] = 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6;
        for (int v = 0; v < 2; v++) begin
            send(vin[v], 1'b1, ok);
            wait_out(got, cyc);
            checks++;
            if (!ok || cyc != 4 || got !== vexp[v]) begin
                errors++;
                $display("FAIL inv_vec%0d got %h (lat %0d) want %h (lat 4)", v, got, cyc, vexp[v]);
            end
            pop();
        end
    endtask

    task automatic test_random();
        logic [127:0] s;
        logic [127:0] got;
        logic [127:0] fwd;
        logic         iv;
        int           cyc;
        bit           ok;
        for (int n = 0; n < 10; n++) begin
            s  = rand128();
            iv = 1'($urandom_range(0, 1));
            send(s, iv, ok);
            wait_out(got, cyc);
            checks++;
            if (!ok || cyc < 0 || got !== mix_model(s, iv)) begin
                errors++;
                $display("FAIL random%0d inv=%b got %h want %h", n, iv, got, mix_model(s, iv));
            end
            pop();
        end
        // Round trip: InvMixColumns must undo MixColumns.
        s = rand128();
        send(s, 1'b0, ok);
        wait_out(fwd, cyc);
        pop();
        send(fwd, 1'b1, ok);
        wait_out(got, cyc);
        pop();
        checks++;
        if (got !== s) begin
            errors++;
            $display("FAIL round_trip got %h want %h", got, s);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] s;
        logic [127:0] got;
        logic [127:0] want;
        int           cyc;
        int           bad;
        bit           ok;
        s    = rand128();
        want = mix_model(s, 1'b0);
        send(s, 1'b0, ok);
        wait_out(got, cyc);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            state_in = rand128();
            inv      = ~inv;
            tick();
            if (state_out !== want || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        in_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL backpressure_hold got %0d unstable cycles want 0 (state_out %h want %h)",
                     bad, state_out, want);
        end
        pop();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] vec [3];
        logic         ivs [3];
        logic [127:0] got [$];
        int           acc_t [$];
        int           idx;
        logic         pre_rdy;
        for (int i = 0; i < 3; i++) begin
            vec[i] = rand128();
            ivs[i] = 1'($urandom_range(0, 1));
        end
        idx       = 0;
        state_in  = vec[0];
        inv       = ivs[0];
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int t = 0; t < 60 && got.size() < 3; t++) begin
            pre_rdy = in_ready;
            if (out_valid) got.push_back(state_out);
            tick();
            if (pre_rdy && in_valid) begin
                acc_t.push_back(t);
                idx++;
                if (idx < 3) begin
                    state_in = vec[idx];
                    inv      = ivs[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (got.size() != 3 || acc_t.size() != 3) begin
            errors++;
            $display("FAIL b2b_count got %0d results %0d accepts want 3 3", got.size(), acc_t.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got[i] !== mix_model(vec[i], ivs[i])) begin
                    errors++;
                    $display("FAIL b2b_result%0d got %h want %h", i, got[i], mix_model(vec[i], ivs[i]));
                end
            end
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (acc_t[i] - acc_t[i-1] != 6) begin
                    errors++;
                    $display("FAIL b2b_spacing%0d got %0d want 6", i, acc_t[i] - acc_t[i-1]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        logic [127:0] s;
        logic [127:0] got;
        int           cyc;
        bit           ok;
        send(rand128(), 1'b1, ok);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || state_out !== 128'h0) begin
            errors++;
            $display("FAIL reset_mid_busy got out_valid=%b in_ready=%b state_out=%h want 0 1 0",
                     out_valid, in_ready, state_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        s = rand128();
        send(s, 1'b0, ok);
        wait_out(got, cyc);
        checks++;
        if (!ok || cyc != 4 || got !== mix_model(s, 1'b0)) begin
            errors++;
            $display("FAIL after_reset got %h (lat %0d) want %h (lat 4)", got, cyc, mix_model(s, 1'b0));
        end
        pop();
    endtask

    task automatic test_ignored_input();
        logic [127:0] s;
        logic [127:0] got;
        int           cyc;
        int           extra;
        bit           ok;
        s = rand128();
        send(s, 1'b1, ok);
        tick();
        in_valid = 1'b1;
        state_in = rand128();
        inv      = 1'b0;
        tick();
        in_valid = 1'b0;
        wait_out(got, cyc);
        checks++;
        if (cyc < 0 || got !== mix_model(s, 1'b1)) begin
            errors++;
            $display("FAIL ignored_result got %h want %h", got, mix_model(s, 1'b1));
        end
        pop();
        out_ready = 1'b1;
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) extra++;
            tick();
        end
        out_ready = 1'b0;
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL ignored_single_output got %0d extra handshakes want 0", extra);
        end
    endtask

    initial begin
        test_reset();
        test_fips_forward();
        test_inverse();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_busy();
        test_ignored_input();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
